sys_arith_sum_arb: RTL and testbench

SYS_ARITH_SUM_ARB -- requirements
Module: sys_arith_sum_arb

---
 rtl/sys_arith_sum_arb.sv | 151 +++++++++++++++
 tb/tb_sys_arith_sum_arb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sys_arith_sum_arb.sv
// Round-robin arbiter feeding a 1+2+...+N summation engine with a held response.
// Define SYS_ARITH_SUM_FAST_EN for a one-cycle closed-form datapath instead of the iterative adder.
module sys_arith_sum_arb #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 32,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_num,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DW-1:0]         rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // req_ready is offered only in IDLE; rsp_valid stays high with stable data until taken.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     ptr_n;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     cand;
    logic [NUM_REQ-1:0] grant;
    logic               found;
    logic               accept;
    logic [DW-1:0]      num_arr [NUM_REQ];
    logic [DW-1:0]      sel_num;
    logic [DW-1:0]      num;
    logic [DW-1:0]      acc;
    logic [DW-1:0]      k;
    logic [IDW-1:0]     id;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign num_arr[i] = req_num[i*DW +: DW];
    end

    // First valid requester scanning upward from ptr, wrapping at NUM_REQ.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = IDW'((int'(ptr) + off) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found           = 1'b1;
                grant[cand]     = 1'b1;
                grant_idx       = cand;
            end
        end
    end

    assign req_ready = (state == IDLE && rst_n) ? grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign sel_num   = num_arr[grant_idx];
    assign ptr_n     = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);

`ifdef SYS_ARITH_SUM_FAST_EN
    // N*(N+1)/2 without a wide product: halve whichever factor is even first.
    logic [DW:0]   n_plus1;
    logic [DW-1:0] fa;
    logic [DW-1:0] fb;
    logic [DW-1:0] closed;

    always_comb begin
        n_plus1 = {1'b0, num} + {{DW{1'b0}}, 1'b1};
        if (num[0]) begin
            fa = n_plus1[DW:1];
            fb = num;
        end else begin
            fa = num >> 1;
            fb = n_plus1[DW-1:0];
        end
        closed = fa * fb;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef SYS_ARITH_SUM_FAST_EN
                    state_n = CALC;
`else
                    state_n = (sel_num == '0) ? RESP : CALC;
`endif
                end
            end
            CALC: begin
`ifdef SYS_ARITH_SUM_FAST_EN
                state_n = RESP;
`else
                if (k == num) state_n = RESP;
`endif
            end
            RESP: begin
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            num <= '0;
            acc <= '0;
            k   <= '0;
            id  <= '0;
        end else if (accept) begin
            ptr <= ptr_n;
            num <= sel_num;
            id  <= grant_idx;
            acc <= '0;
            k   <= {{(DW-1){1'b0}}, 1'b1};
        end else if (state == CALC) begin
`ifdef SYS_ARITH_SUM_FAST_EN
            acc <= closed;
`else
            acc <= acc + k;
            k   <= k + {{(DW-1){1'b0}}, 1'b1};
`endif
        end
    end

    assign rsp_valid = (state == RESP);
    assign rsp_data  = acc;
    assign rsp_id    = id;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sys_arith_sum_arb.sv
// Directed and randomized checks of sys_arith_sum_arb against a closed-form sum and round-robin model.
module tb_sys_arith_sum_arb;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_num;
    logic [NR-1:0]    req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DW-1:0]    rsp_data;
    logic [IW-1:0]    rsp_id;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int ptr_m = 0;
    logic [DW-1:0] exp_q[$];

    sys_arith_sum_arb #(.NUM_REQ(NR), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_num   (req_num),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] sum_model(input logic [DW-1:0] n);
        longint unsigned x;
        x = 64'(n);
        return DW'((x * (x + 64'd1)) / 64'd2);
    endfunction

    function automatic int pick(input logic [NR-1:0] mask);
        for (int off = 0; off < NR; off++) begin
            if (mask[(ptr_m + off) % NR]) return (ptr_m + off) % NR;
        end
        return 0;
    endfunction

    function automatic int exp_lat(input logic [DW-1:0] n);
`ifdef SYS_ARITH_SUM_FAST_EN
        return 2;
`else
        return (n == '0) ? 1 : int'(n) + 1;
`endif
    endfunction

    task automatic set_num(input int i, input logic [DW-1:0] v);
        req_num[i*DW +: DW] = v;
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge after the response handshake.
    task automatic do_op(input logic [NR-1:0] mask, input int hold, input bit keep);
        int            g;
        int            c;
        int            lim;
        logic [DW-1:0] n;
        logic [DW-1:0] expd;
        g = pick(mask);
        req_valid = mask;
        #1;
        check("grant", 64'(req_ready), 64'(NR'(1) << g));
        n = req_num[g*DW +: DW];
        exp_q.push_back(sum_model(n));
        @(posedge clk);
        ptr_m = (g + 1) % NR;
        @(negedge clk);
        if (!keep) begin
            req_valid = NR'($urandom_range(0, 15));
            for (int i = 0; i < NR; i++) set_num(i, DW'($urandom));
        end
        c   = 1;
        lim = exp_lat(n) + 5;
        while (rsp_valid !== 1'b1 && c < lim) begin
            @(negedge clk);
            c++;
        end
        check("latency", 64'(c), 64'(exp_lat(n)));
        expd = exp_q.pop_front();
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 64'(rsp_valid), 64'(1));
            check("hold_data", 64'(rsp_data), 64'(expd));
            check("hold_id", 64'(rsp_id), 64'(g));
            check("hold_no_ready", 64'(req_ready), 64'(0));
            @(negedge clk);
        end
        check("rsp_data", 64'(rsp_data), 64'(expd));
        check("rsp_id", 64'(rsp_id), 64'(g));
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_after_rsp", 64'(busy), 64'(0));
        if (!keep) req_valid = '0;
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        req_num   = '0;
        for (int i = 0; i < NR; i++) set_num(i, DW'($urandom_range(1, 9)));

        // Reset values while rst_n is low, with requests pending.
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        check("rst_rsp_id", 64'(rsp_id), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b0;
        req_valid = '0;
        @(negedge clk);

        // Single requester, N=4 then N=0.
        set_num(0, 32'd4);
        do_op(4'b0001, 0, 1'b0);
        set_num(0, 32'd0);
        do_op(4'b0001, 2, 1'b0);

        // Fresh reset so round robin starts at requester 0.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        @(negedge clk);
        for (int i = 0; i < NR; i++) set_num(i, 32'd1);
        for (int r = 0; r < 5; r++) do_op('1, 0, 1'b1);
        req_valid = '0;

        // Consumer stalls for 10 cycles.
        set_num(1, 32'd3);
        do_op(4'b0010, 10, 1'b0);

        // Random masks, lengths and stalls.
        repeat (20) begin
            for (int i = 0; i < NR; i++) set_num(i, DW'($urandom_range(0, 40)));
            do_op(NR'($urandom_range(1, 15)), $urandom_range(0, 3), 1'b0);
        end

        // Reset while an N=100 operation is in flight.
        set_num(2, 32'd100);
        req_valid = 4'b0100;
        #1;
        check("mid_grant", 64'(req_ready), 64'(NR'(1) << pick(4'b0100)));
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        repeat (10) @(negedge clk);
        check("mid_busy", 64'(busy), 64'(1));
        #2;
        rst_n     = 1'b0;
        req_valid = '1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_rsp_data", 64'(rsp_data), 64'(0));
        check("mid_rst_rsp_id", 64'(rsp_id), 64'(0));
        check("mid_rst_req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        rst_n     = 1'b1;
        ptr_m     = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        seen      = 0;
        repeat (120) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        rsp_ready = 1'b0;
        check("no_rsp_after_rst", 64'(seen), 64'(0));
        for (int i = 0; i < NR; i++) set_num(i, 32'd5);
        do_op('1, 0, 1'b0);

        // Large N: sum exceeds 2^31.
        set_num(3, 32'd65536);
        do_op(4'b1000, 0, 1'b0);
`ifdef SYS_ARITH_SUM_FAST_EN
        set_num(0, 32'hFFFF_FFFF);
        do_op(4'b0001, 1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
